// File: rtl/cpu_fetch_decode.sv
// MCS8 fetch/decode front end: assembles 1-3 byte instructions from a byte stream and queues them.
// Optional HLT fetch stall is enabled with `define CPU_FETCH_DECODE_HLT_STALL_EN.
module cpu_fetch_decode #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 14
) (
   input  logic                     CLK_I,
   input  logic                     RSTN_I,
   input  logic [7:0]               BYTE_I,
   input  logic                     BYTE_VLD_I,
   output logic                     BYTE_RDY_O,
   input  logic                     FLUSH_I,
   input  logic [ADDR_W-1:0]        FLUSH_PC_I,
   output logic                     INS_VLD_O,
   input  logic                     INS_RDY_I,
   output logic [7:0]               OP_O,
   output logic [15:0]              IMM_O,
   output logic [1:0]               LEN_O,
   output logic [ADDR_W-1:0]        PC_O,
   output logic [22:0]              CLS_O,
   output logic [$clog2(DEPTH):0]   LVL_O
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [22:0] LEN2_MASK = 23'h000340;
   localparam logic [22:0] LEN3_MASK = 23'h007800;

   typedef enum logic [1:0] {S_OP, S_B2, S_B3} state_t;

   function automatic logic [22:0] classify(input logic [7:0] op);
      logic [22:0] c;
      logic [2:0]  hi;
      logic [2:0]  lo;
      c  = '0;
      hi = op[5:3];
      lo = op[2:0];
      case (op[7:6])
         2'b00: begin
            case (lo)
               3'd0: if (hi == 3'd0) c[0] = 1'b1; else if (hi == 3'd7) c[22] = 1'b1; else c[2] = 1'b1;
               3'd1: if (hi == 3'd0) c[0] = 1'b1; else if (hi == 3'd7) c[22] = 1'b1; else c[3] = 1'b1;
               3'd2: if (!op[5]) c[4] = 1'b1; else c[22] = 1'b1;
               3'd3: c[5] = 1'b1;
               3'd4: c[6] = 1'b1;
               3'd5: c[7] = 1'b1;
               3'd6: if (hi == 3'd7) c[9] = 1'b1; else c[8] = 1'b1;
               default: c[10] = 1'b1;
            endcase
         end
         2'b01: begin
            if (op[0]) begin
               if (op[5:4] == 2'b00) c[15] = 1'b1; else c[16] = 1'b1;
            end else begin
               case (op[2:1])
                  2'd0:    c[11] = 1'b1;
                  2'd1:    c[12] = 1'b1;
                  2'd2:    c[13] = 1'b1;
                  default: c[14] = 1'b1;
               endcase
            end
         end
         2'b10: if (lo == 3'd7) c[18] = 1'b1; else c[17] = 1'b1;
         default: begin
            if (hi == 3'd7 && lo == 3'd7)  c[1]  = 1'b1;
            else if (hi == 3'd7)           c[21] = 1'b1;
            else if (lo == 3'd7)           c[20] = 1'b1;
            else                           c[19] = 1'b1;
         end
      endcase
      return c;
   endfunction

   function automatic logic [1:0] ins_len(input logic [22:0] c);
      if (|(c & LEN2_MASK))      return 2'd2;
      else if (|(c & LEN3_MASK)) return 2'd3;
      else                       return 2'd1;
   endfunction

   state_t            state;
   logic [ADDR_W-1:0] pc_q;
   logic [7:0]        cur_op;
   logic [ADDR_W-1:0] cur_pc;
   logic [7:0]        cur_imm;
   logic              byte_rdy_q;
   logic [CW-1:0]     cnt;
   logic [PW-1:0]     rd_ptr;
   logic [PW-1:0]     wr_ptr;

   logic [7:0]        q_op  [DEPTH];
   logic [15:0]       q_imm [DEPTH];
   logic [1:0]        q_len [DEPTH];
   logic [ADDR_W-1:0] q_pc  [DEPTH];
   logic [22:0]       q_cls [DEPTH];

   logic              byte_acc;
   logic [7:0]        dec_op;
   logic [22:0]       dec_cls;
   logic [1:0]        dec_len;
   logic              push;
   logic              pop;
   logic [15:0]       push_imm;
   logic [ADDR_W-1:0] push_pc;
   logic [CW-1:0]     cnt_next;
   logic              halt_next;
   logic              rdy_next;

   // The opcode being decoded is the live byte in S_OP and the latched one afterwards.
   always_comb begin
      byte_acc = BYTE_VLD_I & byte_rdy_q;
      dec_op   = (state == S_OP) ? BYTE_I : cur_op;
      dec_cls  = classify(dec_op);
      dec_len  = ins_len(dec_cls);
      push     = 1'b0;
      push_imm = 16'h0000;
      push_pc  = (state == S_OP) ? pc_q : cur_pc;
      case (state)
         S_OP: push = byte_acc && (dec_len == 2'd1);
         S_B2: begin
            push     = byte_acc && (dec_len == 2'd2);
            push_imm = {8'h00, BYTE_I};
         end
         S_B3: begin
            push     = byte_acc;
            push_imm = {BYTE_I, cur_imm};
         end
         default: push = 1'b0;
      endcase
      pop      = (cnt != '0) & INS_RDY_I;
      cnt_next = cnt + CW'(push) - CW'(pop);
      rdy_next = !FLUSH_I && (cnt_next < CW'(DEPTH)) && !halt_next;
   end

`ifdef CPU_FETCH_DECODE_HLT_STALL_EN
   logic halt_q;

   assign halt_next = halt_q | (push & dec_cls[1]);

   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I)      halt_q <= 1'b0;
      else if (FLUSH_I) halt_q <= 1'b0;
      else              halt_q <= halt_next;
   end
`else
   assign halt_next = 1'b0;
`endif

   // Flush wins over any byte or pop in the same cycle.
   always_ff @(posedge CLK_I or negedge RSTN_I) begin
      if (!RSTN_I) begin
         state      <= S_OP;
         pc_q       <= '0;
         cur_op     <= 8'h00;
         cur_pc     <= '0;
         cur_imm    <= 8'h00;
         byte_rdy_q <= 1'b0;
         cnt        <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            q_op[i]  <= 8'h00;
            q_imm[i] <= 16'h0000;
            q_len[i] <= 2'd0;
            q_pc[i]  <= '0;
            q_cls[i] <= '0;
         end
      end else if (FLUSH_I) begin
         state      <= S_OP;
         pc_q       <= FLUSH_PC_I;
         byte_rdy_q <= 1'b0;
         cnt        <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         byte_rdy_q <= rdy_next;
         cnt        <= cnt_next;
         if (byte_acc) begin
            pc_q <= pc_q + 1'b1;
            case (state)
               S_OP: begin
                  cur_op <= BYTE_I;
                  cur_pc <= pc_q;
                  state  <= (dec_len == 2'd1) ? S_OP : S_B2;
               end
               S_B2: begin
                  cur_imm <= BYTE_I;
                  state   <= (dec_len == 2'd2) ? S_OP : S_B3;
               end
               default: state <= S_OP;
            endcase
         end
         if (push) begin
            q_op[wr_ptr]  <= dec_op;
            q_imm[wr_ptr] <= push_imm;
            q_len[wr_ptr] <= dec_len;
            q_pc[wr_ptr]  <= push_pc;
            q_cls[wr_ptr] <= dec_cls;
            wr_ptr        <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   assign BYTE_RDY_O = byte_rdy_q;
   assign INS_VLD_O  = (cnt != '0);
   assign LVL_O      = cnt;
   assign OP_O       = q_op[rd_ptr];
   assign IMM_O      = q_imm[rd_ptr];
   assign LEN_O      = q_len[rd_ptr];
   assign PC_O       = q_pc[rd_ptr];
   assign CLS_O      = q_cls[rd_ptr];

endmodule

// File: tb/tb_cpu_fetch_decode.sv
// Scoreboard bench for cpu_fetch_decode: directed byte streams, opcode sweep, backpressure and flush.
module tb_cpu_fetch_decode;

   logic        CLK_I = 1'b0;
   logic        RSTN_I;
   logic [7:0]  BYTE_I;
   logic        BYTE_VLD_I;
   logic        BYTE_RDY_O;
   logic        FLUSH_I;
   logic [13:0] FLUSH_PC_I;
   logic        INS_VLD_O;
   logic        INS_RDY_I;
   logic [7:0]  OP_O;
   logic [15:0] IMM_O;
   logic [1:0]  LEN_O;
   logic [13:0] PC_O;
   logic [22:0] CLS_O;
   logic [2:0]  LVL_O;

   typedef struct {
      logic [7:0]  op;
      logic [15:0] imm;
      logic [1:0]  len;
      logic [13:0] pc;
      logic [22:0] cls;
   } exp_t;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   logic [13:0] pc_model = '0;
   logic        rst_done = 1'b0;

   cpu_fetch_decode #(.DEPTH(4), .ADDR_W(14)) dut (
      .CLK_I(CLK_I), .RSTN_I(RSTN_I), .BYTE_I(BYTE_I), .BYTE_VLD_I(BYTE_VLD_I),
      .BYTE_RDY_O(BYTE_RDY_O), .FLUSH_I(FLUSH_I), .FLUSH_PC_I(FLUSH_PC_I),
      .INS_VLD_O(INS_VLD_O), .INS_RDY_I(INS_RDY_I), .OP_O(OP_O), .IMM_O(IMM_O),
      .LEN_O(LEN_O), .PC_O(PC_O), .CLS_O(CLS_O), .LVL_O(LVL_O)
   );

   always #5 CLK_I = ~CLK_I;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference classifier written as an ordered wildcard table.
   function automatic int ref_class(input logic [7:0] op);
      casez (op)
         8'b0000000?: return 0;
         8'b11111111: return 1;
         8'b00???000: return (op[5:3] == 3'b111) ? 22 : 2;
         8'b00???001: return (op[5:3] == 3'b111) ? 22 : 3;
         8'b000??010: return 4;
         8'b00???011: return 5;
         8'b00???100: return 6;
         8'b00???101: return 7;
         8'b00111110: return 9;
         8'b00???110: return 8;
         8'b00???111: return 10;
         8'b01???000: return 11;
         8'b01???010: return 12;
         8'b01???100: return 13;
         8'b01???110: return 14;
         8'b0100???1: return 15;
         8'b01?????1: return 16;
         8'b10???111: return 18;
         8'b10??????: return 17;
         8'b11111???: return 21;
         8'b11???111: return 20;
         8'b11??????: return 19;
         default:     return 22;
      endcase
   endfunction

   function automatic int ref_len(input int idx);
      if (idx == 6 || idx == 8 || idx == 9) return 2;
      if (idx >= 11 && idx <= 14)           return 3;
      return 1;
   endfunction

   // Presents one byte and waits for it to be accepted; returns at posedge+1.
   task automatic apply_stimulus(input logic [7:0] b);
      int n;
      n = 0;
      BYTE_I     = b;
      BYTE_VLD_I = 1'b1;
      @(negedge CLK_I);
      while (!BYTE_RDY_O && n < 200) begin
         @(negedge CLK_I);
         n++;
      end
      if (!BYTE_RDY_O) begin
         checks++;
         errors++;
         $display("[TB] FAIL byte_accept_timeout: byte %h never accepted, ready %b expected 1", b, BYTE_RDY_O);
      end
      @(posedge CLK_I);
      #1;
      BYTE_VLD_I = 1'b0;
      pc_model   = pc_model + 14'd1;
   endtask

   task automatic issue_ins(input logic [7:0] op, input logic [7:0] b2, input logic [7:0] b3,
                            input int len, input int idx);
      exp_t e;
      e.op  = op;
      e.len = 2'(len);
      e.pc  = pc_model;
      e.cls = 23'd1 << idx;
      e.imm = (len == 3) ? {b3, b2} : (len == 2) ? {8'h00, b2} : 16'h0000;
      exp_q.push_back(e);
      apply_stimulus(op);
      if (len > 1) apply_stimulus(b2);
      if (len > 2) apply_stimulus(b3);
   endtask

   task automatic do_flush(input logic [13:0] pc);
      FLUSH_I    = 1'b1;
      FLUSH_PC_I = pc;
      exp_q.delete();
      @(posedge CLK_I);
      #1;
      FLUSH_I  = 1'b0;
      pc_model = pc;
   endtask

   task automatic drain();
      int n;
      n = 0;
      INS_RDY_I = 1'b1;
      while ((exp_q.size() != 0 || INS_VLD_O) && n < 200) begin
         @(posedge CLK_I);
         #1;
         n++;
      end
      if (n >= 200) begin
         checks++;
         errors++;
         $display("[TB] FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
      end
   endtask

   // Monitor: every handshake that pops the head is compared with the scoreboard.
   always @(negedge CLK_I) begin
      if (rst_done && INS_VLD_O && INS_RDY_I && !FLUSH_I) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_entry: op %h pc %h, expected no entry", OP_O, PC_O);
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("mon_op",  32'(OP_O),  32'(e.op));
            check_output("mon_imm", 32'(IMM_O), 32'(e.imm));
            check_output("mon_len", 32'(LEN_O), 32'(e.len));
            check_output("mon_pc",  32'(PC_O),  32'(e.pc));
            check_output("mon_cls", 32'(CLS_O), 32'(e.cls));
         end
      end
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [7:0] op;
      int idx;
      RSTN_I     = 1'b0;
      BYTE_I     = 8'h00;
      BYTE_VLD_I = 1'b0;
      FLUSH_I    = 1'b0;
      FLUSH_PC_I = '0;
      INS_RDY_I  = 1'b0;
      repeat (2) @(negedge CLK_I);
      check_output("rst_rdy", 32'(BYTE_RDY_O), 32'd0);
      check_output("rst_vld", 32'(INS_VLD_O),  32'd0);
      check_output("rst_lvl", 32'(LVL_O),      32'd0);
      check_output("rst_op",  32'(OP_O),       32'd0);
      check_output("rst_imm", 32'(IMM_O),      32'd0);
      check_output("rst_len", 32'(LEN_O),      32'd0);
      check_output("rst_pc",  32'(PC_O),       32'd0);
      check_output("rst_cls", 32'(CLS_O),      32'd0);
      @(posedge CLK_I);
      #1;
      RSTN_I   = 1'b1;
      rst_done = 1'b1;

      $display("[TB] directed NOP / LRI / JMP stream");
      INS_RDY_I = 1'b1;
      issue_ins(8'h00, 8'h00, 8'h00, 1, 0);
      issue_ins(8'h06, 8'h2A, 8'h00, 2, 8);
      issue_ins(8'h44, 8'h34, 8'h12, 3, 13);
      drain();
      check_output("lvl_after_drain", 32'(LVL_O), 32'd0);

      $display("[TB] backpressure with full queue");
      INS_RDY_I = 1'b0;
      for (int i = 0; i < 4; i++) issue_ins(8'hC1, 8'h00, 8'h00, 1, 19);
      @(negedge CLK_I);
      check_output("full_lvl", 32'(LVL_O),      32'd4);
      check_output("full_rdy", 32'(BYTE_RDY_O), 32'd0);
      @(posedge CLK_I);
      #1;
      begin
         exp_t e;
         e.op = 8'hC1; e.imm = 16'h0000; e.len = 2'd1; e.pc = pc_model; e.cls = 23'd1 << 19;
         exp_q.push_back(e);
      end
      BYTE_I     = 8'hC1;
      BYTE_VLD_I = 1'b1;
      repeat (2) @(posedge CLK_I);
      #1;
      check_output("full_hold_lvl", 32'(LVL_O), 32'd4);
      INS_RDY_I = 1'b1;
      @(posedge CLK_I);
      #1;
      INS_RDY_I = 1'b0;
      @(negedge CLK_I);
      check_output("pop_rdy", 32'(BYTE_RDY_O), 32'd1);
      check_output("pop_lvl", 32'(LVL_O),      32'd3);
      @(posedge CLK_I);
      #1;
      BYTE_VLD_I = 1'b0;
      pc_model   = pc_model + 14'd1;
      @(negedge CLK_I);
      check_output("refill_lvl", 32'(LVL_O), 32'd4);
      @(posedge CLK_I);
      #1;
      drain();

      $display("[TB] flush mid-instruction");
      apply_stimulus(8'h46);
      apply_stimulus(8'h10);
      do_flush(14'h0100);
      @(negedge CLK_I);
      check_output("flush_lvl", 32'(LVL_O),     32'd0);
      check_output("flush_vld", 32'(INS_VLD_O), 32'd0);
      @(posedge CLK_I);
      #1;
      issue_ins(8'hFF, 8'h00, 8'h00, 1, 1);
      drain();

      $display("[TB] opcode sweep");
      do_flush(14'h0000);
      issue_ins(8'h38, 8'h00, 8'h00, 1, 22);
      for (int i = 0; i < 256; i++) begin
         op  = 8'(i);
         idx = ref_class(op);
         issue_ins(op, op ^ 8'h5A, ~op, ref_len(idx), idx);
      end
      drain();

      $display("[TB] PC wrap");
      do_flush(14'h3FFF);
      issue_ins(8'h00, 8'h00, 8'h00, 1, 0);
      issue_ins(8'h00, 8'h00, 8'h00, 1, 0);
      drain();

`ifdef CPU_FETCH_DECODE_HLT_STALL_EN
      $display("[TB] HLT stall");
      do_flush(14'h0020);
      INS_RDY_I = 1'b0;
      issue_ins(8'hFF, 8'h00, 8'h00, 1, 1);
      @(negedge CLK_I);
      check_output("halt_rdy", 32'(BYTE_RDY_O), 32'd0);
      @(posedge CLK_I);
      #1;
      BYTE_I     = 8'h00;
      BYTE_VLD_I = 1'b1;
      repeat (4) @(posedge CLK_I);
      #1;
      check_output("halt_lvl", 32'(LVL_O), 32'd1);
      BYTE_VLD_I = 1'b0;
      drain();
      check_output("halt_drained_rdy", 32'(BYTE_RDY_O), 32'd0);
      do_flush(14'h0000);
      @(posedge CLK_I);
      #1;
      check_output("halt_release_rdy", 32'(BYTE_RDY_O), 32'd1);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
